axi_arbiter_s2m_n: RTL and testbench
====================================

AXI_ARBITER_S2M_N -- requirements
Module: axi_arbiter_s2m_n

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4, meaning number of slave response ports arbitrated (2..16).
REQ-002 SHALL have parameter LOCK_BURST, default 1, meaning 1 holds the R grant until the RLAST beat and 0 releases it after any single beat.
REQ-003 SHALL have parameter IDW, default 2, meaning width of the grant index outputs, equal to ceil(log2(NUM_SLV)) with a minimum of 1.
REQ-004 SHALL have port AXI_CLK  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port AXI_RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port BSELECT  input  NUM_SLV  slave i's B response targets this master.
REQ-007 SHALL have port BVALID  input  NUM_SLV  per-slave BVALID.
REQ-008 SHALL have port BREADY  input  NUM_SLV  per-slave view of the master's BREADY.
REQ-009 SHALL have port BGRANT  output  NUM_SLV  one-hot or zero B grant.
REQ-010 SHALL have port BGRANT_ID  output  IDW  binary index of the B grant holder, valid while BBUSY=1.
REQ-011 SHALL have port BBUSY  output  1  B channel grant held.
REQ-012 SHALL have ports RSELECT, RVALID, RREADY and RLAST  input  NUM_SLV each  per-slave read-data signals, with the same meaning as the B inputs.
REQ-013 SHALL have port RGRANT  output  NUM_SLV  one-hot or zero R grant.
REQ-014 SHALL have port RGRANT_ID  output  IDW  binary index of the R grant holder, valid while RBUSY=1.
REQ-015 SHALL have port RBUSY  output  1  R channel grant held.

Function
REQ-016 SHALL run two independent, identical arbiters, B and R; the items below apply to each, with the B channel's LAST tied to 1.
REQ-017 SHALL define the request vector as REQ[i] = SELECT[i] & VALID[i].
REQ-018 SHALL implement a two-state FSM per channel, IDLE and BUSY, with GRANT, GRANT_ID and BUSY all registered outputs.
REQ-019 SHALL, in IDLE with REQ nonzero, select a winner by round-robin: first set bit searching upward from index ptr+1 mod NUM_SLV.
REQ-020 SHALL then, on the next cycle, assert GRANT = one-hot winner, GRANT_ID = winner index, BUSY = 1, and enter BUSY; grant latency from request is 1 cycle.
REQ-021 SHALL stay in IDLE with GRANT = 0 while REQ is zero.
REQ-022 SHALL, in BUSY, hold GRANT and GRANT_ID unchanged regardless of REQ, SELECT or VALID changes, including the holder deasserting VALID.
REQ-023 SHALL detect completion in BUSY as |(GRANT & VALID & READY & LASTQ), where LASTQ = RLAST for R when LOCK_BURST=1 and all-ones otherwise.
REQ-024 SHALL, on completion, set GRANT = 0, BUSY = 0 and ptr = GRANT_ID on the next cycle and return to IDLE.
REQ-025 SHALL insert exactly one IDLE cycle between consecutive grants on the same channel; that cycle is used for re-arbitration.
REQ-026 SHALL, with LOCK_BURST=1, ignore beats with RLAST=0: the grant stays and ptr is unchanged.
REQ-027 SHALL ignore READY without VALID, and VALID without READY, for completion.
REQ-028 SHALL have the B and R arbiters share no state; simultaneous completions on both channels are processed independently in the same cycle.
REQ-029 SHALL wrap ptr from NUM_SLV-1 to 0; with only one requester present, that requester SHALL be re-granted after each completion.
REQ-030 SHALL never assert more than one GRANT bit, and SHALL never assert GRANT[i] in a cycle where BUSY=0.

Reset
REQ-031 SHALL, when AXI_RST=1 at a clock edge, set GRANT = 0, GRANT_ID = 0, BUSY = 0, state = IDLE and ptr = NUM_SLV-1, so slave 0 has first priority.
REQ-032 SHALL let reset asserted mid-burst abort the grant immediately on that edge; the next grant SHALL require a fresh arbitration after reset deasserts.

Verification
REQ-033 SHALL cover: reset, then RSELECT=RVALID=4'b0110 -> RGRANT=4'b0010, RGRANT_ID=1 one cycle later; after its RLAST handshake, 4'b0100 is granted two cycles after completion.
REQ-034 SHALL cover: LOCK_BURST=1, a 4-beat burst from slave 3 with a slave 0 request pending -> RGRANT stays 4'b1000 through beats 1-3 and drops only after the beat-4 RLAST handshake.
REQ-035 SHALL cover: LOCK_BURST=0, with the same stimulus as REQ-034 -> the grant drops after beat 1 and slave 0 is granted next.
REQ-036 SHALL cover: all four BVALID held high with BREADY=1 -> BGRANT cycles 0001, 0010, 0100, 1000, 0001 with a zero cycle between each.
REQ-037 SHALL cover: B and R completing in the same cycle on different slaves -> both grants drop next cycle and each ptr updates correctly.
REQ-038 SHALL cover: AXI_RST pulsed for one cycle during an R burst (beat 2 of 4) -> RGRANT=0 and RBUSY=0 the next cycle, and slave 0 wins if it is requesting.

Source files
------------

// File: rtl/axi_arbiter_s2m_n.sv
// ---------------------------------------------------------------------------
// axi_arbiter_s2m_n
//   Response-side (slave-to-master) arbiter for one AXI master. Two fully
//   independent round-robin arbiters pick which slave may drive the B and R
//   channels back to this master. A grant is held until the transfer
//   completes (the RLAST beat for R when LOCK_BURST=1, any beat otherwise;
//   any B beat), followed by one idle re-arbitration cycle.
//
// Ports
//   AXI_CLK            clock, all logic on its rising edge
//   AXI_RST            synchronous active-high reset
//   BSELECT/BVALID     per-slave B request (slave targets this master, valid)
//   BREADY             per-slave view of the master's BREADY
//   BGRANT/BGRANT_ID   one-hot B grant and its binary index (index valid
//   BBUSY              while BBUSY=1); BBUSY = B grant held
//   RSELECT/RVALID/    per-slave R request, handshake and last-beat flag
//   RREADY/RLAST
//   RGRANT/RGRANT_ID   one-hot R grant and its binary index (index valid
//   RBUSY              while RBUSY=1); RBUSY = R grant held
// ---------------------------------------------------------------------------

// One channel's arbiter: IDLE/BUSY FSM with registered grant outputs.
module axi_arbiter_s2m_n_chan #(
    parameter int NUM_SLV = 4,
    parameter int IDW     = 2
) (
    input  logic               AXI_CLK,
    input  logic               AXI_RST,
    input  logic [NUM_SLV-1:0] SELECT,
    input  logic [NUM_SLV-1:0] VALID,
    input  logic [NUM_SLV-1:0] READY,
    input  logic [NUM_SLV-1:0] LASTQ,
    output logic [NUM_SLV-1:0] GRANT,
    output logic [IDW-1:0]     GRANT_ID,
    output logic               BUSY
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_SLV-1:0] grant_d;
    logic [IDW-1:0]     grant_id_d;
    logic               busy_d;

    logic [NUM_SLV-1:0] req;
    logic               found;
    logic [IDW-1:0]     winner;
    logic               done;

    assign req  = SELECT & VALID;
    // Only the holder's own handshake on its final beat ends the grant.
    assign done = |(GRANT & VALID & READY & LASTQ);

    // Round-robin search: first requester strictly after the last holder,
    // wrapping from NUM_SLV-1 back to 0.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_SLV; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SLV) idx = idx - NUM_SLV;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = GRANT;
        grant_id_d = GRANT_ID;
        busy_d     = BUSY;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (found) begin
                    state_d    = ST_BUSY;
                    grant_d    = NUM_SLV'(1) << winner;
                    grant_id_d = winner;
                    busy_d     = 1'b1;
                end
            end
            ST_BUSY: begin
                // Grant is frozen regardless of request changes until done.
                if (done) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = GRANT_ID;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge AXI_CLK) begin
        if (AXI_RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IDW'(NUM_SLV - 1);   // slave 0 has first priority
            GRANT    <= '0;
            GRANT_ID <= '0;
            BUSY     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            GRANT    <= grant_d;
            GRANT_ID <= grant_id_d;
            BUSY     <= busy_d;
        end
    end

endmodule

module axi_arbiter_s2m_n #(
    parameter int NUM_SLV    = 4,
    parameter int LOCK_BURST = 1,
    parameter int IDW        = 2
) (
    input  logic               AXI_CLK,
    input  logic               AXI_RST,
    input  logic [NUM_SLV-1:0] BSELECT,
    input  logic [NUM_SLV-1:0] BVALID,
    input  logic [NUM_SLV-1:0] BREADY,
    output logic [NUM_SLV-1:0] BGRANT,
    output logic [IDW-1:0]     BGRANT_ID,
    output logic               BBUSY,
    input  logic [NUM_SLV-1:0] RSELECT,
    input  logic [NUM_SLV-1:0] RVALID,
    input  logic [NUM_SLV-1:0] RREADY,
    input  logic [NUM_SLV-1:0] RLAST,
    output logic [NUM_SLV-1:0] RGRANT,
    output logic [IDW-1:0]     RGRANT_ID,
    output logic               RBUSY
);

    logic [NUM_SLV-1:0] b_lastq;
    logic [NUM_SLV-1:0] r_lastq;

    // B responses are single-beat; R releases on RLAST only when locking.
    assign b_lastq = '1;
    assign r_lastq = (LOCK_BURST != 0) ? RLAST : '1;

    axi_arbiter_s2m_n_chan #(.NUM_SLV(NUM_SLV), .IDW(IDW)) u_b_arb (
        .AXI_CLK  (AXI_CLK),
        .AXI_RST  (AXI_RST),
        .SELECT   (BSELECT),
        .VALID    (BVALID),
        .READY    (BREADY),
        .LASTQ    (b_lastq),
        .GRANT    (BGRANT),
        .GRANT_ID (BGRANT_ID),
        .BUSY     (BBUSY)
    );

    axi_arbiter_s2m_n_chan #(.NUM_SLV(NUM_SLV), .IDW(IDW)) u_r_arb (
        .AXI_CLK  (AXI_CLK),
        .AXI_RST  (AXI_RST),
        .SELECT   (RSELECT),
        .VALID    (RVALID),
        .READY    (RREADY),
        .LASTQ    (r_lastq),
        .GRANT    (RGRANT),
        .GRANT_ID (RGRANT_ID),
        .BUSY     (RBUSY)
    );

endmodule

// File: tb/tb_axi_arbiter_s2m_n.sv
// ---------------------------------------------------------------------------
// tb_axi_arbiter_s2m_n
//   Self-checking bench for axi_arbiter_s2m_n. Two instances share inputs:
//   dut (LOCK_BURST=1) and dut_nl (LOCK_BURST=0). Each scenario is a table of
//   per-cycle rows; applying a row drives the inputs and queues the outputs
//   expected after the next rising edge, which are then popped and compared.
// ---------------------------------------------------------------------------
module tb_axi_arbiter_s2m_n;

    localparam int SRC_R    = 0;   // dut R channel
    localparam int SRC_NL   = 1;   // dut_nl R channel
    localparam int SRC_B    = 2;   // dut B channel
    localparam int SRC_NONE = 3;

    typedef struct packed {
        logic [1:0] src;
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] rsel, rval, rrdy, rlast;
        logic [3:0] bsel, bval, brdy;
        exp_t       ea, eb;
    } row_t;

    logic       AXI_CLK;
    logic       AXI_RST;
    logic [3:0] BSELECT, BVALID, BREADY;
    logic [3:0] RSELECT, RVALID, RREADY, RLAST;
    logic [3:0] BGRANT, RGRANT;
    logic [1:0] BGRANT_ID, RGRANT_ID;
    logic       BBUSY, RBUSY;
    logic [3:0] nl_bgrant, nl_rgrant;
    logic [1:0] nl_bgrant_id, nl_rgrant_id;
    logic       nl_bbusy, nl_rbusy;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    axi_arbiter_s2m_n #(.NUM_SLV(4), .LOCK_BURST(1), .IDW(2)) dut (
        .AXI_CLK(AXI_CLK), .AXI_RST(AXI_RST),
        .BSELECT(BSELECT), .BVALID(BVALID), .BREADY(BREADY),
        .BGRANT(BGRANT), .BGRANT_ID(BGRANT_ID), .BBUSY(BBUSY),
        .RSELECT(RSELECT), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
        .RGRANT(RGRANT), .RGRANT_ID(RGRANT_ID), .RBUSY(RBUSY)
    );

    axi_arbiter_s2m_n #(.NUM_SLV(4), .LOCK_BURST(0), .IDW(2)) dut_nl (
        .AXI_CLK(AXI_CLK), .AXI_RST(AXI_RST),
        .BSELECT(BSELECT), .BVALID(BVALID), .BREADY(BREADY),
        .BGRANT(nl_bgrant), .BGRANT_ID(nl_bgrant_id), .BBUSY(nl_bbusy),
        .RSELECT(RSELECT), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
        .RGRANT(nl_rgrant), .RGRANT_ID(nl_rgrant_id), .RBUSY(nl_rbusy)
    );

    initial begin
        AXI_CLK = 1'b0;
        forever #5 AXI_CLK = ~AXI_CLK;
    end

    function automatic exp_t ex(input int src, input logic [3:0] g,
                                input logic [1:0] id, input logic b);
        exp_t e;
        e.src   = 2'(src);
        e.grant = g;
        e.id    = id;
        e.busy  = b;
        return e;
    endfunction

    function automatic row_t row(input logic rst,
                                 input logic [3:0] rsel, rval, rrdy, rlast,
                                 input logic [3:0] bsel, bval, brdy,
                                 input exp_t ea, input exp_t eb);
        row_t r;
        r.rst = rst;
        r.rsel = rsel; r.rval = rval; r.rrdy = rrdy; r.rlast = rlast;
        r.bsel = bsel; r.bval = bval; r.brdy = brdy;
        r.ea = ea; r.eb = eb;
        return r;
    endfunction

    function automatic logic [6:0] observe(input logic [1:0] src);
        case (src)
            2'd0:    return {RGRANT, RGRANT_ID, RBUSY};
            2'd1:    return {nl_rgrant, nl_rgrant_id, nl_rbusy};
            2'd2:    return {BGRANT, BGRANT_ID, BBUSY};
            default: return 7'd0;
        endcase
    endfunction

    // Drive one row's inputs and queue the outputs it should produce.
    task automatic apply(input row_t r);
        AXI_RST = r.rst;
        RSELECT = r.rsel; RVALID = r.rval; RREADY = r.rrdy; RLAST = r.rlast;
        BSELECT = r.bsel; BVALID = r.bval; BREADY = r.brdy;
        if (r.ea.src != 2'(SRC_NONE)) sb_q.push_back(r.ea);
        if (r.eb.src != 2'(SRC_NONE)) sb_q.push_back(r.eb);
    endtask

    task automatic step();
        @(posedge AXI_CLK);
        #1;
    endtask

    exp_t none_e;
    initial none_e = '{src: 2'(SRC_NONE), grant: 4'd0, id: 2'd0, busy: 1'b0};

    task automatic test_reset();
        row_t rows[$];
        rows.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, ex(SRC_R, 0, 0, 0), ex(SRC_B, 0, 0, 0)));
        rows.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, ex(SRC_NL, 0, 0, 0), none_e));
        foreach (rows[i]) begin
            apply(rows[i]);
            step();
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [6:0] obs, mask;
                e    = sb_q.pop_front();
                obs  = observe(e.src);
                mask = e.busy ? 7'h7f : 7'h79;
                n_checks++;
                if ((obs & mask) !== ({e.grant, e.id, e.busy} & mask))
                    $display("FAIL reset row %0d src %0d: got %b, want %b",
                             i, e.src, obs, {e.grant, e.id, e.busy});
                else
                    n_pass++;
            end
        end
        n_checks++;
        if (RGRANT_ID !== 2'd0) $display("FAIL reset_rgrant_id: got %b, want 00", RGRANT_ID);
        else n_pass++;
        n_checks++;
        if (BGRANT_ID !== 2'd0) $display("FAIL reset_bgrant_id: got %b, want 00", BGRANT_ID);
        else n_pass++;
    endtask

    task automatic test_rr_basic();
        row_t rows[$];
        rows.push_back(row(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0010, 1, 1), none_e));
        rows.push_back(row(0, 4'b0110, 4'b0110, 4'b1111, 4'b0110, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0100, 2, 1), none_e));
        rows.push_back(row(0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        foreach (rows[i]) begin
            apply(rows[i]);
            step();
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [6:0] obs, mask;
                e    = sb_q.pop_front();
                obs  = observe(e.src);
                mask = e.busy ? 7'h7f : 7'h79;
                n_checks++;
                if ((obs & mask) !== ({e.grant, e.id, e.busy} & mask))
                    $display("FAIL rr_basic row %0d: got %b, want %b", i, obs, {e.grant, e.id, e.busy});
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_hold();
        row_t rows[$];
        rows.push_back(row(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0010, 1, 1), none_e));
        // READY without VALID, then VALID without READY: no completion.
        rows.push_back(row(0, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 0, 0, 0, ex(SRC_R, 4'b0010, 1, 1), none_e));
        rows.push_back(row(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 0, 0, ex(SRC_R, 4'b0010, 1, 1), none_e));
        // Non-holders complete handshakes while the holder is idle.
        rows.push_back(row(0, 4'b0000, 4'b1101, 4'b1101, 4'b1111, 0, 0, 0, ex(SRC_R, 4'b0010, 1, 1), none_e));
        rows.push_back(row(0, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        // Lone requester is re-granted after its own completion.
        rows.push_back(row(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0010, 1, 1), none_e));
        foreach (rows[i]) begin
            apply(rows[i]);
            step();
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [6:0] obs, mask;
                e    = sb_q.pop_front();
                obs  = observe(e.src);
                mask = e.busy ? 7'h7f : 7'h79;
                n_checks++;
                if ((obs & mask) !== ({e.grant, e.id, e.busy} & mask))
                    $display("FAIL hold row %0d: got %b, want %b", i, obs, {e.grant, e.id, e.busy});
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_lock_burst();
        row_t rows[$];
        rows.push_back(row(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b1000, 3, 1), none_e));
        for (int b = 0; b < 3; b++)
            rows.push_back(row(0, 4'b1001, 4'b1001, 4'b1000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b1000, 3, 1), none_e));
        rows.push_back(row(0, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0001, 0, 1), none_e));
        foreach (rows[i]) begin
            apply(rows[i]);
            step();
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [6:0] obs, mask;
                e    = sb_q.pop_front();
                obs  = observe(e.src);
                mask = e.busy ? 7'h7f : 7'h79;
                n_checks++;
                if ((obs & mask) !== ({e.grant, e.id, e.busy} & mask))
                    $display("FAIL lock_burst row %0d: got %b, want %b", i, obs, {e.grant, e.id, e.busy});
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_lock0();
        row_t rows[$];
        rows.push_back(row(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_NL, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_NL, 4'b1000, 3, 1), none_e));
        rows.push_back(row(0, 4'b1001, 4'b1001, 4'b1000, 4'b0000, 0, 0, 0, ex(SRC_NL, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_NL, 4'b0001, 0, 1), none_e));
        foreach (rows[i]) begin
            apply(rows[i]);
            step();
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [6:0] obs, mask;
                e    = sb_q.pop_front();
                obs  = observe(e.src);
                mask = e.busy ? 7'h7f : 7'h79;
                n_checks++;
                if ((obs & mask) !== ({e.grant, e.id, e.busy} & mask))
                    $display("FAIL lock0 row %0d: got %b, want %b", i, obs, {e.grant, e.id, e.busy});
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_b_rr();
        row_t rows[$];
        logic [3:0] g;
        rows.push_back(row(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, ex(SRC_B, 4'b0000, 0, 0), none_e));
        for (int k = 0; k < 9; k++) begin
            g = (k % 2 == 0) ? 4'(1 << ((k / 2) % 4)) : 4'b0000;
            rows.push_back(row(0, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'b1111,
                               ex(SRC_B, g, 2'((k / 2) % 4), (k % 2 == 0)), none_e));
        end
        foreach (rows[i]) begin
            apply(rows[i]);
            step();
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [6:0] obs, mask;
                e    = sb_q.pop_front();
                obs  = observe(e.src);
                mask = e.busy ? 7'h7f : 7'h79;
                n_checks++;
                if ((obs & mask) !== ({e.grant, e.id, e.busy} & mask))
                    $display("FAIL b_rr row %0d: got %b, want %b", i, obs, {e.grant, e.id, e.busy});
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_simultaneous();
        row_t rows[$];
        rows.push_back(row(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                           ex(SRC_R, 4'b0000, 0, 0), ex(SRC_B, 4'b0000, 0, 0)));
        rows.push_back(row(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000,
                           ex(SRC_R, 4'b0010, 1, 1), ex(SRC_B, 4'b0100, 2, 1)));
        rows.push_back(row(0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100,
                           ex(SRC_R, 4'b0000, 0, 0), ex(SRC_B, 4'b0000, 0, 0)));
        // Different winners here prove each pointer moved to its own holder.
        rows.push_back(row(0, 4'b1101, 4'b1101, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0000,
                           ex(SRC_R, 4'b0100, 2, 1), ex(SRC_B, 4'b1000, 3, 1)));
        foreach (rows[i]) begin
            apply(rows[i]);
            step();
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [6:0] obs, mask;
                e    = sb_q.pop_front();
                obs  = observe(e.src);
                mask = e.busy ? 7'h7f : 7'h79;
                n_checks++;
                if ((obs & mask) !== ({e.grant, e.id, e.busy} & mask))
                    $display("FAIL simultaneous row %0d src %0d: got %b, want %b",
                             i, e.src, obs, {e.grant, e.id, e.busy});
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        row_t rows[$];
        rows.push_back(row(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0010, 1, 1), none_e));
        rows.push_back(row(0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0100, 2, 1), none_e));
        rows.push_back(row(0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0100, 2, 1), none_e));
        rows.push_back(row(1, 4'b0101, 4'b0101, 4'b0100, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0000, 0, 0), none_e));
        rows.push_back(row(0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, ex(SRC_R, 4'b0001, 0, 1), none_e));
        foreach (rows[i]) begin
            apply(rows[i]);
            step();
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [6:0] obs, mask;
                e    = sb_q.pop_front();
                obs  = observe(e.src);
                mask = e.busy ? 7'h7f : 7'h79;
                n_checks++;
                if ((obs & mask) !== ({e.grant, e.id, e.busy} & mask))
                    $display("FAIL reset_mid_burst row %0d: got %b, want %b", i, obs, {e.grant, e.id, e.busy});
                else
                    n_pass++;
            end
        end
    endtask

    initial begin
        AXI_RST = 1'b1;
        BSELECT = '0; BVALID = '0; BREADY = '0;
        RSELECT = '0; RVALID = '0; RREADY = '0; RLAST = '0;
        test_reset();
        test_rr_basic();
        test_hold();
        test_lock_burst();
        test_lock0();
        test_b_rr();
        test_simultaneous();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
